sbp_pipeline_scheduler: RTL and testbench
=========================================

// Module: sbp_pipeline_scheduler
// PURPOSE
// Sits at the head of the sbp_lookup_stage chain and is its only source of slots. Each cycle it injects
// one lookup, one update (memory write) or a bubble. Lookups are credit-limited against the downstream
// result FIFO. Update batches are atomic, so no lookup sees a half-written tree. A burst counter stops
// lookups from starving pending updates.
// PARAMETERS
// STAGE_ID_BITS   6    width of stage_id fields (stage 0 = no stage, used for bubbles)
// LOCATION_BITS   11   width of location fields
// RESULT_BITS     24   width of result field (nibble-padded stage/location/child layout)
// ROOT_STAGE_ID   1    stage holding the trie root; every lookup starts here at location 0
// MAX_INFLIGHT    32   lookup credits = result FIFO depth downstream
// LOOKUP_BURST    8    max consecutive lookups granted while an update is pending
// PORTS
// clk              in   1    clock
// rst              in   1    synchronous reset, active-high
// lookup_valid_i   in   1    lookup request valid
// lookup_ready_o   out  1    lookup accepted when valid&ready
// lookup_ip_i      in   32   IP address to look up
// upd_valid_i      in   1    update word valid
// upd_ready_o      out  1    update accepted when valid&ready
// upd_last_i       in   1    last word of the update batch
// upd_prefix_i     in   32   prefix to write
// upd_length_i     in   6    prefix length
// upd_stage_id_i   in   STAGE_ID_BITS   target stage
// upd_location_i   in   LOCATION_BITS   target location
// upd_result_i     in   RESULT_BITS     child/result word to write
// credit_return_i  in   1    pulse: one result popped from the downstream FIFO
// update_o, ip_addr_o[31:0], bit_pos_o[5:0], stage_id_o, location_o, result_o   out   pipeline head slot
// busy_o           out  1    batch in progress (state UPDATE)
// credits_o        out  $clog2(MAX_INFLIGHT+1)   free lookup credits
// BEHAVIOUR
// - State machine: LOOKUP and UPDATE.
// - Grant, decided combinationally from registered state:
//   - LOOKUP: grant the update if upd_valid_i && (!lookup_valid_i || burst==LOOKUP_BURST || credits==0).
//     Otherwise grant the lookup if lookup_valid_i && credits>0.
//   - UPDATE: only updates are granted; upd_ready_o=1 and lookup_ready_o=0.
// - ready outputs equal the grant for that requester.
// - Update accepted in LOOKUP with !upd_last_i -> UPDATE.
// - Update accepted in UPDATE with upd_last_i -> LOOKUP. A single-word batch (last=1 in LOOKUP) stays in LOOKUP.
// - Burst counter:
//   - increments, saturating at LOOKUP_BURST, on a lookup grant while upd_valid_i=1;
//   - clears on any update grant, and on a lookup grant while upd_valid_i=0.
// - Credits:
//   - -1 on lookup grant, +1 on credit_return_i; both in the same cycle = no change;
//   - a return while credits==MAX_INFLIGHT is ignored (saturate; assertion fires in simulation).
// - Slot outputs are registered, 1-cycle latency from handshake:
//   - lookup slot: update_o=0, ip_addr_o=lookup_ip_i, bit_pos_o=0, stage_id_o=ROOT_STAGE_ID, location_o=0, result_o=0.
//   - update slot: update_o=1, ip_addr_o=upd_prefix_i, bit_pos_o=upd_length_i, stage_id_o=upd_stage_id_i,
//     location_o=upd_location_i, result_o=upd_result_i.
//   - bubble when no grant: all slot outputs 0. stage_id 0 matches no stage.
// - Reset (at any time, including mid-batch):
//   - state LOOKUP, burst=0, credits=MAX_INFLIGHT, all slot outputs 0, busy_o=0;
//   - a partially written batch is the controller's responsibility to re-send.
// - Unused upd_* in UPDATE while upd_valid_i=0: emit bubbles and stay in UPDATE; lookups remain blocked.
// STRUCTURE
// - sbp_pkg holds: STAGE_ID_BITS, LOCATION_BITS, BIT_POS_BITS, PAD_* and RESULT_BITS derivation;
//   sbp_slot_t struct {update, ip_addr, bit_pos, stage_id, location, result}; and the state enum.
// - One sub-module: sbp_credit_counter (MAX parameter, take/give inputs, count/nonzero outputs, saturating).
// TESTING
// - Lookups only:
//   - 3 lookups back-to-back -> stage_id_o=1, location_o=0, bit_pos_o=0, update_o=0 on cycles 1..3;
//   - credits_o 32 -> 29.
// - Credit exhaustion (MAX_INFLIGHT=4): 6 lookups, no returns -> 4 issued, then lookup_ready_o=0;
//   one credit_return_i -> the 5th lookup issues next cycle.
// - Atomic batch: 3-word update (last on word 3) with lookups pending -> 3 consecutive update_o=1 slots;
//   zero lookups in between; busy_o high from cycle after word 1 until word 3 accepted.
// - Anti-starvation (LOOKUP_BURST=8): continuous lookups plus an update at cycle 2 -> exactly 8 lookups,
//   then the update, then lookups resume.
// - Simultaneous take+return at credits=1 -> credits stay 1.
// - Reset asserted mid-batch after word 1 -> next cycle busy_o=0, credits full, slot outputs zero,
//   lookups accepted again.

Source files
------------

// File: rtl/sbp_pkg.sv
// sbp_pkg: shared widths, pipeline slot layout and scheduler state encoding
package sbp_pkg;

    localparam int STAGE_ID_BITS = 6;
    localparam int LOCATION_BITS = 11;
    localparam int BIT_POS_BITS  = 6;
    localparam int CHILD_BITS    = 4;
    localparam int PAD_STAGE     = (4 - STAGE_ID_BITS % 4) % 4;
    localparam int PAD_LOCATION  = (4 - LOCATION_BITS % 4) % 4;
    localparam int RESULT_BITS   = STAGE_ID_BITS + PAD_STAGE + LOCATION_BITS + PAD_LOCATION + CHILD_BITS;

    typedef struct packed {
        logic                     update;
        logic [31:0]              ip_addr;
        logic [BIT_POS_BITS-1:0]  bit_pos;
        logic [STAGE_ID_BITS-1:0] stage_id;
        logic [LOCATION_BITS-1:0] location;
        logic [RESULT_BITS-1:0]   result;
    } sbp_slot_t;

    typedef enum logic {
        ST_LOOKUP,
        ST_UPDATE
    } sched_state_t;

endpackage

// File: rtl/sbp_credit_counter.sv
// sbp_credit_counter: saturating free-slot counter for the downstream result FIFO
module sbp_credit_counter #(
    parameter int MAX = 32,
    localparam int CW = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          take,
    input  logic          give,
    output logic [CW-1:0] count,
    output logic          nonzero
);

    assign nonzero = count != '0;

    // take and give together cancel; a give while already full is dropped
    always_ff @(posedge clk) begin
        if (rst)
            count <= CW'(MAX);
        else if (take && !give)
            count <= count - 1'b1;
        else if (give && !take && count != CW'(MAX))
            count <= count + 1'b1;
    end

    // a return with no credit outstanding means the downstream bookkeeping is broken
    always_ff @(posedge clk) begin
        if (!rst && give && !take)
            assert (count != CW'(MAX)) else $error("credit return while all credits free");
    end

endmodule

// File: rtl/sbp_pipeline_scheduler.sv
// sbp_pipeline_scheduler: arbitrates lookups and atomic update batches into the lookup pipeline head
module sbp_pipeline_scheduler
    import sbp_pkg::*;
#(
    parameter int ROOT_STAGE_ID = 1,
    parameter int MAX_INFLIGHT  = 32,
    parameter int LOOKUP_BURST  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              lookup_valid_i,
    output logic                              lookup_ready_o,
    input  logic [31:0]                       lookup_ip_i,
    input  logic                              upd_valid_i,
    output logic                              upd_ready_o,
    input  logic                              upd_last_i,
    input  logic [31:0]                       upd_prefix_i,
    input  logic [BIT_POS_BITS-1:0]           upd_length_i,
    input  logic [STAGE_ID_BITS-1:0]          upd_stage_id_i,
    input  logic [LOCATION_BITS-1:0]          upd_location_i,
    input  logic [RESULT_BITS-1:0]            upd_result_i,
    input  logic                              credit_return_i,
    output logic                              update_o,
    output logic [31:0]                       ip_addr_o,
    output logic [BIT_POS_BITS-1:0]           bit_pos_o,
    output logic [STAGE_ID_BITS-1:0]          stage_id_o,
    output logic [LOCATION_BITS-1:0]          location_o,
    output logic [RESULT_BITS-1:0]            result_o,
    output logic                              busy_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] credits_o
);

    localparam int BW = $clog2(LOOKUP_BURST + 1);

    sched_state_t state, state_next;
    logic [BW-1:0] burst, burst_next;
    logic          in_update, upd_grant, lk_grant, credits_nz;
    sbp_slot_t     slot, slot_next;

    sbp_credit_counter #(.MAX(MAX_INFLIGHT)) u_credits (
        .clk     (clk),
        .rst     (rst),
        .take    (lk_grant),
        .give    (credit_return_i),
        .count   (credits_o),
        .nonzero (credits_nz)
    );

    // grant arbitration, next state, burst tracking and the slot to inject
    always_comb begin
        in_update  = state == ST_UPDATE;
        upd_grant  = in_update ? upd_valid_i
                   : upd_valid_i && (!lookup_valid_i || burst == BW'(LOOKUP_BURST) || !credits_nz);
        lk_grant   = !in_update && !upd_grant && lookup_valid_i && credits_nz;
        state_next = upd_grant ? (upd_last_i ? ST_LOOKUP : ST_UPDATE) : state;
        burst_next = upd_grant ? '0
                   : !lk_grant ? burst
                   : !upd_valid_i ? '0
                   : burst == BW'(LOOKUP_BURST) ? burst : burst + 1'b1;
        lookup_ready_o = lk_grant;
        upd_ready_o    = in_update || upd_grant;
        slot_next      = '0;
        if (upd_grant)
            slot_next = '{update: 1'b1, ip_addr: upd_prefix_i, bit_pos: upd_length_i,
                          stage_id: upd_stage_id_i, location: upd_location_i, result: upd_result_i};
        else if (lk_grant)
            slot_next = '{update: 1'b0, ip_addr: lookup_ip_i, bit_pos: '0,
                          stage_id: STAGE_ID_BITS'(ROOT_STAGE_ID), location: '0, result: '0};
    end

    // state, burst counter and registered pipeline head slot
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOOKUP;
            burst <= '0;
            slot  <= '0;
        end else begin
            state <= state_next;
            burst <= burst_next;
            slot  <= slot_next;
        end
    end

    assign update_o   = slot.update;
    assign ip_addr_o  = slot.ip_addr;
    assign bit_pos_o  = slot.bit_pos;
    assign stage_id_o = slot.stage_id;
    assign location_o = slot.location;
    assign result_o   = slot.result;
    assign busy_o     = state == ST_UPDATE;

endmodule

// File: tb/tb_sbp_pipeline_scheduler.sv
// tb_sbp_pipeline_scheduler: directed and random checks of the scheduler against a cycle model
module tb_sbp_pipeline_scheduler;

    localparam int MAX  = 4;
    localparam int LB   = 8;
    localparam int ROOT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_ip = '0;
    logic        upd_valid = 1'b0;
    logic        upd_last = 1'b0;
    logic [31:0] upd_prefix = '0;
    logic [5:0]  upd_length = '0;
    logic [5:0]  upd_stage_id = '0;
    logic [10:0] upd_location = '0;
    logic [23:0] upd_result = '0;
    logic        credit_return = 1'b0;

    logic        lookup_ready, upd_ready, update, busy;
    logic [31:0] ip_addr;
    logic [5:0]  bit_pos, stage_id;
    logic [10:0] location;
    logic [23:0] result;
    logic [2:0]  credits;

    logic        lookup_ready32, upd_ready32, update32, busy32;
    logic [31:0] ip_addr32;
    logic [5:0]  bit_pos32, stage_id32;
    logic [10:0] location32;
    logic [23:0] result32;
    logic [5:0]  credits32;

    int n_assert = 0;
    int n_fail = 0;
    int m_cred = MAX;
    int m_run = 0;
    bit m_inb = 1'b0;
    bit gu, gl;
    logic        e_update;
    logic [31:0] e_ip;
    logic [5:0]  e_bp, e_sid;
    logic [10:0] e_loc;
    logic [23:0] e_res;

    always #5 clk = ~clk;

    sbp_pipeline_scheduler #(.MAX_INFLIGHT(MAX), .LOOKUP_BURST(LB)) u_dut (
        .clk(clk), .rst(rst),
        .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready), .lookup_ip_i(lookup_ip),
        .upd_valid_i(upd_valid), .upd_ready_o(upd_ready), .upd_last_i(upd_last),
        .upd_prefix_i(upd_prefix), .upd_length_i(upd_length), .upd_stage_id_i(upd_stage_id),
        .upd_location_i(upd_location), .upd_result_i(upd_result), .credit_return_i(credit_return),
        .update_o(update), .ip_addr_o(ip_addr), .bit_pos_o(bit_pos), .stage_id_o(stage_id),
        .location_o(location), .result_o(result), .busy_o(busy), .credits_o(credits)
    );

    sbp_pipeline_scheduler u_dut32 (
        .clk(clk), .rst(rst),
        .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready32), .lookup_ip_i(lookup_ip),
        .upd_valid_i(upd_valid), .upd_ready_o(upd_ready32), .upd_last_i(upd_last),
        .upd_prefix_i(upd_prefix), .upd_length_i(upd_length), .upd_stage_id_i(upd_stage_id),
        .upd_location_i(upd_location), .upd_result_i(upd_result), .credit_return_i(1'b0),
        .update_o(update32), .ip_addr_o(ip_addr32), .bit_pos_o(bit_pos32), .stage_id_o(stage_id32),
        .location_o(location32), .result_o(result32), .busy_o(busy32), .credits_o(credits32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rnd_upd();
        upd_prefix   = $urandom;
        upd_length   = 6'($urandom);
        upd_stage_id = 6'($urandom);
        upd_location = 11'($urandom);
        upd_result   = 24'($urandom);
    endtask

    // one clock: check ready against the model, advance the model, check registered outputs
    task automatic cyc();
        #2;
        gu = m_inb ? upd_valid : upd_valid && (!lookup_valid || m_run == LB || m_cred == 0);
        gl = !m_inb && !gu && lookup_valid && m_cred > 0;
        if (!rst) begin
            chk("lookup_ready", lookup_ready, gl);
            chk("upd_ready", upd_ready, m_inb || gu);
        end
        if (rst) begin
            gu = 1'b0;
            gl = 1'b0;
        end
        e_update = gu;
        e_ip     = gu ? upd_prefix : gl ? lookup_ip : '0;
        e_bp     = gu ? upd_length : '0;
        e_sid    = gu ? upd_stage_id : gl ? 6'(ROOT) : '0;
        e_loc    = gu ? upd_location : '0;
        e_res    = gu ? upd_result : '0;
        if (rst) begin
            m_inb  = 1'b0;
            m_run  = 0;
            m_cred = MAX;
        end else begin
            m_cred = m_cred - int'(gl) + int'(credit_return);
            if (m_cred > MAX) m_cred = MAX;
            if (gu) begin
                m_run = 0;
                m_inb = !upd_last;
            end else if (gl)
                m_run = !upd_valid ? 0 : (m_run < LB ? m_run + 1 : LB);
        end
        @(posedge clk);
        #1;
        chk("busy", busy, m_inb);
        chk("credits", credits, m_cred);
        chk("update", update, e_update);
        chk("ip_addr", ip_addr, e_ip);
        chk("bit_pos", bit_pos, e_bp);
        chk("stage_id", stage_id, e_sid);
        chk("location", location, e_loc);
        chk("result", result, e_res);
    endtask

    task automatic refill();
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
        repeat (MAX + 1) begin
            credit_return = m_cred < MAX;
            cyc();
        end
        credit_return = 1'b0;
    endtask

    initial begin
        int issued, w, ups, gap, cnt;
        bit got;
        // reset
        cyc();
        cyc();
        rst = 1'b0;
        chk("reset_credits", credits, MAX);
        chk("reset_credits32", credits32, 32);
        chk("reset_stage", stage_id, 0);

        // lookups only: root stage slots, credits drain by three
        lookup_valid = 1'b1;
        repeat (3) begin
            lookup_ip = $urandom;
            cyc();
            chk("d32_update", update32, 0);
            chk("d32_stage", stage_id32, ROOT);
            chk("d32_ip", ip_addr32, lookup_ip);
        end
        lookup_valid = 1'b0;
        cyc();
        chk("d32_credits", credits32, 29);
        chk("lookups_credits", credits, MAX - 3);

        // credit exhaustion, then one return releases the next lookup
        refill();
        lookup_valid = 1'b1;
        issued = 0;
        repeat (6) begin
            lookup_ip = $urandom;
            cyc();
            issued += int'(gl);
        end
        chk("exhaust_issued", issued, MAX);
        chk("exhaust_ready", lookup_ready, 0);
        credit_return = 1'b1;
        cyc();
        chk("return_cycle_bubble", stage_id, 0);
        credit_return = 1'b0;
        cyc();
        chk("fifth_lookup", stage_id, ROOT);
        lookup_valid = 1'b0;

        // atomic three-word batch competing with lookups
        refill();
        lookup_valid = 1'b1;
        upd_valid = 1'b1;
        upd_last = 1'b0;
        rnd_upd();
        w = 0;
        ups = 0;
        gap = 0;
        for (int k = 0; k < 40 && w < 3; k++) begin
            lookup_ip = $urandom;
            cyc();
            if (update) ups++;
            else if (ups > 0) gap++;
            if (gu) begin
                w++;
                upd_last = w == 2;
                rnd_upd();
                if (w < 3) chk("batch_busy", busy, 1);
            end
        end
        upd_valid = 1'b0;
        upd_last = 1'b0;
        lookup_valid = 1'b0;
        chk("batch_words", w, 3);
        chk("batch_gap", gap, 0);
        chk("batch_done_busy", busy, 0);

        // anti-starvation: exactly LB lookups while the update waits
        refill();
        lookup_valid = 1'b1;
        upd_last = 1'b1;
        cnt = 0;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 2) upd_valid = 1'b1;
            credit_return = m_cred < MAX;
            lookup_ip = $urandom;
            cyc();
            if (upd_valid && gl) cnt++;
            if (gu) begin
                got = 1'b1;
                break;
            end
        end
        upd_valid = 1'b0;
        chk("burst_update_granted", got, 1);
        chk("burst_lookups", cnt, LB);
        chk("burst_update_slot", update, 1);
        credit_return = m_cred < MAX;
        cyc();
        chk("burst_resume", stage_id, ROOT);
        credit_return = 1'b0;

        // simultaneous take and return at one credit
        for (int k = 0; k < 10 && m_cred > 1; k++) cyc();
        credit_return = 1'b1;
        cyc();
        chk("take_give_credits", credits, 1);
        chk("take_give_lookup", stage_id, ROOT);
        credit_return = 1'b0;
        lookup_valid = 1'b0;

        // reset in the middle of a batch
        upd_valid = 1'b1;
        upd_last = 1'b0;
        rnd_upd();
        cyc();
        chk("midbatch_busy", busy, 1);
        upd_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_credits", credits, MAX);
        chk("rst_slot", {update, ip_addr, bit_pos, stage_id, location, result}, 0);
        lookup_valid = 1'b1;
        lookup_ip = $urandom;
        cyc();
        chk("rst_lookup", stage_id, ROOT);
        chk("rst_lookup_ip", ip_addr, lookup_ip);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            lookup_valid  = $urandom_range(0, 3) != 0;
            lookup_ip     = $urandom;
            upd_valid     = $urandom_range(0, 2) == 0;
            upd_last      = $urandom_range(0, 2) == 0;
            rnd_upd();
            credit_return = m_cred < MAX && $urandom_range(0, 1) == 1;
            rst           = $urandom_range(0, 63) == 0;
            cyc();
        end
        rst = 1'b0;
        lookup_valid = 1'b0;
        upd_valid = 1'b0;
        credit_return = 1'b0;
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
